alu_iter: RTL and testbench

Execution-stage ALU that consumes the 4-bit ALU control code produced by the ALU controller.
- Logic ops, arithmetic ops and compare complete one cycle after acceptance.
- MUL is computed by an iterative shift-add datapath.
- busy_o stalls the upstream PC/pipeline until done_o pulses.
- Sits between the ALU controller / register file read and the writeback mux.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_iter_if.sv | 24 ++
 rtl/alu_mul_iter.sv | 46 ++++
 rtl/alu_iter.sv | 129 ++++++++++++
 tb/tb_alu_iter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: default width, op codes, FSM states.
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_iter_if.sv
// Request/result bundle between the pipeline and the iterative ALU.
interface alu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ALUCtrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             overflow_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, ALUCtrl_i, src1_i, src2_i,
    input  result_o, zero_o, overflow_o, busy_o, done_o
  );

  modport slave (
    input  start_i, ALUCtrl_i, src1_i, src2_i,
    output result_o, zero_o, overflow_o, busy_o, done_o
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier datapath: one partial-product step per cycle, low WIDTH bits kept.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplier,
  output logic [WIDTH-1:0] o_acc_nxt,
  output logic             o_last
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;

  // Accumulator value after the current step; the parent captures it on the last step.
  assign o_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_last    = (r_cnt == CW'(WIDTH - 1));

  // Operand capture on load, then shift/accumulate once per step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc    <= o_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Execution-stage ALU: single-cycle logic/arith/compare ops, iterative MUL with busy stall.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_iter_if.slave  bus
);

  alu_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_zero, w_zero_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_done, w_done_nxt;

  logic [WIDTH-1:0] w_a, w_b, w_sum, w_diff;
  logic [WIDTH-1:0] w_op_res;
  logic             w_op_ovf;

  logic             w_mul_load;
  logic             w_mul_step;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_mul_acc_nxt;

  assign w_a    = bus.src1_i;
  assign w_b    = bus.src2_i;
  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;

  // Single-cycle operation result and signed overflow.
  always_comb begin
    w_op_res = '0;
    w_op_ovf = 1'b0;
    case (bus.ALUCtrl_i)
      OP_AND: w_op_res = w_a & w_b;
      OP_OR:  w_op_res = w_a | w_b;
      OP_NOR: w_op_res = ~(w_a | w_b);
      OP_ADD: begin
        w_op_res = w_sum;
        w_op_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_op_res = w_diff;
        w_op_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SLT: w_op_res = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      default: begin
        w_op_res = '0;
        w_op_ovf = 1'b0;
      end
    endcase
  end

  // Next state and next output-register values; outputs hold unless an op completes.
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_zero_nxt   = r_zero;
    w_ovf_nxt    = r_ovf;
    w_done_nxt   = 1'b0;
    w_mul_load   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (bus.ALUCtrl_i == OP_MUL) begin
            w_mul_load  = 1'b1;
            w_state_nxt = ST_MUL;
          end else begin
            w_result_nxt = w_op_res;
            w_zero_nxt   = (w_op_res == '0);
            w_ovf_nxt    = w_op_ovf;
            w_done_nxt   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (w_mul_last) begin
          w_result_nxt = w_mul_acc_nxt;
          w_zero_nxt   = (w_mul_acc_nxt == '0);
          w_ovf_nxt    = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_zero   <= w_zero_nxt;
      r_ovf    <= w_ovf_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign w_mul_step = (r_state == ST_MUL);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .i_clk     (clk_i),
    .i_rst_n   (rst_i),
    .i_load    (w_mul_load),
    .i_step    (w_mul_step),
    .i_mcand   (w_a),
    .i_mplier  (w_b),
    .o_acc_nxt (w_mul_acc_nxt),
    .o_last    (w_mul_last)
  );

  assign bus.result_o   = r_result;
  assign bus.zero_o     = r_zero;
  assign bus.overflow_o = r_ovf;
  assign bus.busy_o     = (r_state == ST_MUL);
  assign bus.done_o     = r_done;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter with a latency/arith reference model and per-cycle compare.
module tb_alu_iter;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_iter_if #(.WIDTH(W)) bus ();

  alu_iter #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: arithmetic straight from the op definitions, MUL as a delayed product.
  logic [W-1:0] m_result, m_pend;
  logic         m_zero, m_ovf, m_busy, m_done;
  int           m_left;

  function automatic void m_eval(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [W-1:0] r,
                                 output logic ovf);
    longint sa, sb, s;
    longint maxv, minv;
    sa   = $signed(a);
    sb   = $signed(b);
    maxv = (longint'(1) <<< (W - 1)) - 1;
    minv = -(longint'(1) <<< (W - 1));
    r    = '0;
    ovf  = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin s = sa + sb; r = W'(s); ovf = (s > maxv) || (s < minv); end
      4'b0110: begin s = sa - sb; r = W'(s); ovf = (s > maxv) || (s < minv); end
      4'b0111: r = (sa < sb) ? W'(1) : W'(0);
      default: begin r = '0; ovf = 1'b0; end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] r;
    logic         o;
    if (!rst_n) begin
      m_result = '0; m_zero = 1'b1; m_ovf = 1'b0;
      m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_pend = '0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_result = m_pend; m_zero = (m_pend == '0); m_ovf = 1'b0;
          m_done = 1'b1; m_busy = 1'b0;
        end
      end else if (bus.start_i) begin
        if (bus.ALUCtrl_i == 4'b1000) begin
          m_busy = 1'b1;
          m_left = W;
          m_pend = bus.src1_i * bus.src2_i;
        end else begin
          m_eval(bus.ALUCtrl_i, bus.src1_i, bus.src2_i, r, o);
          m_result = r; m_zero = (r == '0); m_ovf = o; m_done = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_done",   bus.done_o,     m_done);
    chk("cyc_busy",   bus.busy_o,     m_busy);
    chk("cyc_result", bus.result_o,   m_result);
    chk("cyc_zero",   bus.zero_o,     m_zero);
    chk("cyc_ovf",    bus.overflow_o, m_ovf);
  end

  // Called at a negedge: request for one cycle, return at the following negedge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start_i = 1'b1; bus.ALUCtrl_i = op; bus.src1_i = a; bus.src2_i = b;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done_o) chk({name, "_timeout"}, 64'(n), 64'(40 + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, busy_cnt, seen;
    bus.start_i = 1'b0; bus.ALUCtrl_i = 4'b0; bus.src1_i = '0; bus.src2_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", bus.result_o, 0);
    chk("rst_zero",   bus.zero_o, 1);
    chk("rst_busy",   bus.busy_o, 0);
    chk("rst_done",   bus.done_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: AND
    issue(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("and_result", bus.result_o, 32'h00F0_00F0);
    chk("and_done",   bus.done_o, 1);
    chk("and_zero",   bus.zero_o, 0);
    chk("and_busy",   bus.busy_o, 0);

    // 2: ADD overflow, SUB to zero, SUB overflow
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
    chk("add_result", bus.result_o, 32'h8000_0000);
    chk("add_ovf",    bus.overflow_o, 1);
    issue(4'b0110, 32'd5, 32'd5);
    chk("sub_result", bus.result_o, 0);
    chk("sub_zero",   bus.zero_o, 1);
    chk("sub_ovf",    bus.overflow_o, 0);
    issue(4'b0110, 32'h8000_0000, 32'h1);
    chk("sub_ovf_result", bus.result_o, 32'h7FFF_FFFF);
    chk("sub_ovf_flag",   bus.overflow_o, 1);

    // 3: SLT signed, both orders; NOR
    issue(4'b0111, 32'hFFFF_FFFF, 32'h1);
    chk("slt_neg", bus.result_o, 1);
    issue(4'b0111, 32'h1, 32'hFFFF_FFFF);
    chk("slt_pos", bus.result_o, 0);
    issue(4'b1100, 32'h0000_00FF, 32'hFF00_0000);
    chk("nor_result", bus.result_o, 32'h00FF_FF00);

    // Two single-cycle ops back to back
    bus.start_i = 1'b1; bus.ALUCtrl_i = 4'b0001; bus.src1_i = 32'h1; bus.src2_i = 32'h2;
    @(negedge clk);
    bus.ALUCtrl_i = 4'b0010; bus.src1_i = 32'h10; bus.src2_i = 32'h20;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("b2b_result", bus.result_o, 32'h30);
    chk("b2b_done",   bus.done_o, 1);

    // 4: MUL with an ignored AND request mid-iteration
    issue(4'b1000, 32'd12345, 32'd678);
    n = 0; busy_cnt = 0;
    while (!bus.done_o && n < 40) begin
      if (bus.busy_o) busy_cnt++;
      if (n == 10) begin
        bus.start_i = 1'b1; bus.ALUCtrl_i = 4'b0000; bus.src1_i = '1; bus.src2_i = '1;
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start_i = 1'b0;
    chk("mul_latency", 64'(n), 32);
    chk("mul_busy_cycles", 64'(busy_cnt), 32);
    chk("mul_result", bus.result_o, 32'd8369910);
    chk("mul_done_busy", bus.busy_o, 0);

    // 5: MUL wrapping to zero, then ADD accepted in the done cycle
    issue(4'b1000, 32'h0001_0000, 32'h0001_0000);
    wait_done("mul0");
    chk("mul0_result", bus.result_o, 0);
    chk("mul0_zero",   bus.zero_o, 1);
    issue(4'b0010, 32'd3, 32'd4);
    chk("b2b_add_result", bus.result_o, 7);
    chk("b2b_add_done",   bus.done_o, 1);

    // 6: reset mid-MUL, then invalid op
    issue(4'b1000, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", bus.result_o, 0);
    chk("arst_zero",   bus.zero_o, 1);
    chk("arst_busy",   bus.busy_o, 0);
    chk("arst_done",   bus.done_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o) seen++;
    end
    chk("arst_no_done", 64'(seen), 0);
    issue(4'b0010, 32'd1, 32'd1);
    chk("pre_inv_result", bus.result_o, 2);
    issue(4'b1111, 32'd123, 32'd456);
    chk("inv_result", bus.result_o, 0);
    chk("inv_done",   bus.done_o, 1);
    chk("inv_ovf",    bus.overflow_o, 0);
    issue(4'b0011, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    chk("inv2_ovf",   bus.overflow_o, 0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
